// File: rtl/mem_responder_if.sv
// Purpose : request/response bundle between the control unit and mem_responder.
// Latency : none, wires only.
// Backpressure: none; the control unit holds off new strobes while busy is high.
// Signals : MRead/MWrite strobes, lane_mask, addr_flat, wdata_flat (control -> memory);
//           MReady pulse, rdata_flat, busy (memory -> control).
interface mem_responder_if #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8
);
  logic                        MRead;
  logic                        MWrite;
  logic [N_CORES-1:0]          lane_mask;
  logic [N_CORES*ADDR_W-1:0]   addr_flat;
  logic [N_CORES*DATA_W-1:0]   wdata_flat;
  logic                        MReady;
  logic [N_CORES*DATA_W-1:0]   rdata_flat;
  logic                        busy;

  modport master (
    output MRead, MWrite, lane_mask, addr_flat, wdata_flat,
    input  MReady, rdata_flat, busy
  );

  modport slave (
    input  MRead, MWrite, lane_mask, addr_flat, wdata_flat,
    output MReady, rdata_flat, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Purpose : SIMT lane memory; services one lane per cycle from a captured request.
// Latency : strobe accepted at edge T, MReady pulses in the cycle after edge T+N_CORES.
// Backpressure: strobes are ignored while busy; nothing is queued.
// Ports   : clk, reset (sync, active-high), bus (slave side of mem_responder_if).
module mem_responder #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CORES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               op_wr;
  logic [N_CORES-1:0] mask_q;
  logic [ADDR_W-1:0]  addr_q  [N_CORES];
  logic [DATA_W-1:0]  wdata_q [N_CORES];
  logic [DATA_W-1:0]  rdata_q [N_CORES];
  logic               mready_q;
  logic               busy_q;

  // Storage is never reset so contents survive a control-unit reset.
  logic [DATA_W-1:0]  mem [2**ADDR_W];

  logic               wr_en;
  assign wr_en = (state == ACCESS) && op_wr && mask_q[idx];

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[addr_q[idx]] <= wdata_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      mready_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          mready_q <= 1'b0;
          if (bus.MRead || bus.MWrite) begin
            // A store wins when both strobes are high.
            op_wr  <= bus.MWrite;
            mask_q <= bus.lane_mask;
            for (int i = 0; i < N_CORES; i++) begin
              addr_q[i]  <= bus.addr_flat[i*ADDR_W +: ADDR_W];
              wdata_q[i] <= bus.wdata_flat[i*DATA_W +: DATA_W];
            end
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (!op_wr && mask_q[idx]) begin
            rdata_q[idx] <= mem[addr_q[idx]];
          end
          if (idx == LAST_IDX) begin
            mready_q <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          mready_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          mready_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.MReady = mready_q;
  assign bus.busy   = busy_q;

  for (genvar g = 0; g < N_CORES; g++) begin : g_rdata
    assign bus.rdata_flat[g*DATA_W +: DATA_W] = rdata_q[g];
  end

endmodule

// File: tb/tb_mem_responder.sv
// Purpose : directed self-checking bench for mem_responder (4 lanes, 16-bit data, 8-bit addr).
// Latency : n/a.
// Backpressure: n/a.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if #(.N_CORES(4), .DATA_W(16), .ADDR_W(8)) bus ();

  mem_responder #(.N_CORES(4), .DATA_W(16), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mmem [256];
  logic [63:0] exp_rdata;
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    bus.MRead      = 1'b0;
    bus.MWrite     = 1'b0;
    bus.lane_mask  = '0;
    bus.addr_flat  = '0;
    bus.wdata_flat = '0;
  endtask

  // Issue one request, update the model, then watch an 8-cycle window.
  task automatic do_req(input logic rd, input logic wr, input logic [3:0] m,
                        input logic [31:0] a, input logic [63:0] d,
                        input bit poke, input string tag);
    int pulses;
    int first;
    logic [63:0] e;
    if (wr) begin
      for (int i = 0; i < 4; i++) if (m[i]) mmem[a[i*8 +: 8]] = d[i*16 +: 16];
    end else begin
      for (int i = 0; i < 4; i++) if (m[i]) exp_rdata[i*16 +: 16] = mmem[a[i*8 +: 8]];
    end
    exp_q.push_back(exp_rdata);
    e = exp_rdata;
    bus.MRead      = rd;
    bus.MWrite     = wr;
    bus.lane_mask  = m;
    bus.addr_flat  = a;
    bus.wdata_flat = d;
    @(posedge clk); #1;
    // Scramble live inputs: only captured values may be used.
    bus.MRead      = 1'b0;
    bus.MWrite     = 1'b0;
    bus.lane_mask  = ~m;
    bus.addr_flat  = ~a;
    bus.wdata_flat = ~d;
    check({tag, " busy_after_accept"}, {63'd0, bus.busy}, 64'd1);
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus.MReady) begin
        pulses++;
        if (first < 0) begin
          first = k;
          e = exp_q.pop_front();
          check({tag, " rdata"}, bus.rdata_flat, e);
        end
      end
      if (poke) bus.MRead = (k == 1);
    end
    check({tag, " mready_pulses"}, 64'(pulses), 64'd1);
    check({tag, " mready_cycle"}, 64'(first), 64'd4);
    check({tag, " busy_idle"}, {63'd0, bus.busy}, 64'd0);
    check({tag, " rdata_stable"}, bus.rdata_flat, e);
    idle_inputs();
  endtask

  initial begin
    int pulses;
    idle_inputs();
    exp_rdata = '0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst mready", {63'd0, bus.MReady}, 64'd0);
    check("rst busy", {63'd0, bus.busy}, 64'd0);
    check("rst rdata", bus.rdata_flat, 64'd0);
    reset = 1'b0;

    // Full-mask store then load
    do_req(1'b0, 1'b1, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {16'd40, 16'd30, 16'd20, 16'd10}, 1'b0, "st_full");
    do_req(1'b1, 1'b0, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, 64'd0, 1'b0, "ld_full");
    check("ld_full const", bus.rdata_flat, {16'd40, 16'd30, 16'd20, 16'd10});

    // Partial-mask store
    do_req(1'b0, 1'b1, 4'b1111, {8'd8, 8'd7, 8'd6, 8'd5}, 64'd0, 1'b0, "st_zero");
    do_req(1'b0, 1'b1, 4'b0101, {8'd8, 8'd7, 8'd6, 8'd5}, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, "st_part");
    do_req(1'b1, 1'b0, 4'b1111, {8'd8, 8'd7, 8'd6, 8'd5}, 64'd0, 1'b0, "ld_part");
    check("ld_part const", bus.rdata_flat, {16'd0, 16'd3, 16'd0, 16'd1});

    // Same-address store: highest lane wins
    do_req(1'b0, 1'b1, 4'b1111, {8'd9, 8'd9, 8'd9, 8'd9}, {16'd44, 16'd33, 16'd22, 16'd11}, 1'b0, "st_same");
    do_req(1'b1, 1'b0, 4'b1111, {8'd9, 8'd9, 8'd9, 8'd9}, 64'd0, 1'b0, "ld_same");
    check("ld_same const", bus.rdata_flat, {16'd44, 16'd44, 16'd44, 16'd44});

    // Both strobes -> store; extra MRead during ACCESS ignored
    do_req(1'b1, 1'b1, 4'b1111, {8'd33, 8'd32, 8'd31, 8'd30}, {16'hd00d, 16'hc00c, 16'hb00b, 16'ha00a}, 1'b1, "st_both");
    do_req(1'b1, 1'b0, 4'b1111, {8'd33, 8'd32, 8'd31, 8'd30}, 64'd0, 1'b0, "ld_both");

    // Zero-mask load leaves rdata untouched
    do_req(1'b1, 1'b0, 4'b0000, {8'd4, 8'd3, 8'd2, 8'd1}, 64'd0, 1'b0, "ld_nomask");
    check("ld_nomask const", bus.rdata_flat, {16'hd00d, 16'hc00c, 16'hb00b, 16'ha00a});

    // Reset in the second ACCESS cycle of a store
    do_req(1'b0, 1'b1, 4'b1111, {8'd23, 8'd22, 8'd21, 8'd20}, 64'd0, 1'b0, "st_clr");
    mmem[20] = 16'd5;
    bus.MWrite     = 1'b1;
    bus.lane_mask  = 4'b1111;
    bus.addr_flat  = {8'd23, 8'd22, 8'd21, 8'd20};
    bus.wdata_flat = {16'd8, 16'd7, 16'd6, 16'd5};
    @(posedge clk); #1;
    bus.MWrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rdata = '0;
    check("abort busy", {63'd0, bus.busy}, 64'd0);
    check("abort mready", {63'd0, bus.MReady}, 64'd0);
    check("abort rdata", bus.rdata_flat, 64'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.MReady) pulses++;
    end
    check("abort no_pulse", 64'(pulses), 64'd0);
    idle_inputs();
    do_req(1'b1, 1'b0, 4'b1111, {8'd23, 8'd22, 8'd21, 8'd20}, 64'd0, 1'b0, "ld_abort");
    check("ld_abort const", bus.rdata_flat, {16'd0, 16'd0, 16'd0, 16'd5});
    do_req(1'b1, 1'b0, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, 64'd0, 1'b0, "ld_persist");
    check("ld_persist const", bus.rdata_flat, {16'd40, 16'd30, 16'd20, 16'd10});

    // Reset beats a simultaneous strobe
    bus.MWrite = 1'b1;
    bus.lane_mask = 4'b1111;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.MWrite = 1'b0;
    check("rst_prio busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1;
    check("rst_prio busy2", {63'd0, bus.busy}, 64'd0);
    check("rst_prio rdata", bus.rdata_flat, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter N_CORES, default 4: number of SIMT lanes served per request.
REQ-002 SHALL have parameter DATA_W, default 16: lane data width.
REQ-003 SHALL have parameter ADDR_W, default 8: lane word address width; memory depth is 2^ADDR_W words.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port MRead  input  1  load request strobe from the control unit.
REQ-007 SHALL have port MWrite  input  1  store request strobe from the control unit.
REQ-008 SHALL have port lane_mask  input  N_CORES  active-lane mask; bit i enables lane i.
REQ-009 SHALL have port addr_flat  input  N_CORES*ADDR_W  lane i address at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port wdata_flat  input  N_CORES*DATA_W  lane i store data at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port MReady  output  1  one-cycle completion pulse to the control unit.
REQ-012 SHALL have port rdata_flat  output  N_CORES*DATA_W  lane i load data, registered.
REQ-013 SHALL have port busy  output  1  high while a request is in progress (ACCESS or DONE).

Function
REQ-014 SHALL contain an internal storage array of 2^ADDR_W words of DATA_W bits, with no reset of its contents.
REQ-015 SHALL implement states IDLE, ACCESS and DONE.
REQ-016 In IDLE, at a rising edge with MRead or MWrite high, SHALL capture op, lane_mask, addr_flat and wdata_flat, clear lane index to 0, and enter ACCESS.
REQ-017 SHALL give MWrite priority when MRead and MWrite are both high; the request is then a store.
REQ-018 SHALL ignore MRead and MWrite while in ACCESS or DONE; no queuing and no state change.
REQ-019 In ACCESS, each cycle SHALL service the lane at the current index, using captured values only.
REQ-019a Store, captured mask bit set: mem[addr_i] <= wdata_i.
REQ-019b Load, captured mask bit set: rdata lane i <= mem[addr_i].
REQ-019c Captured mask bit clear: no memory write, and rdata lane i holds its prior value.
REQ-020 SHALL increment the lane index after each ACCESS cycle, and enter DONE after lane N_CORES-1.
REQ-021 In DONE, SHALL drive MReady=1 for exactly one cycle, then return to IDLE.
REQ-022 Latency: request sampled at edge T SHALL give ACCESS cycles T..T+N_CORES-1 and MReady high in the cycle after edge T+N_CORES (N_CORES+1 cycles for N_CORES=4, independent of mask).
REQ-023 An all-zero captured mask SHALL still traverse all ACCESS cycles and pulse MReady, with no memory or rdata change.
REQ-024 Multiple active lanes storing to the same address SHALL resolve in ascending lane order; the highest active lane's data persists.
REQ-025 A load SHALL return memory contents including all stores completed before the load was accepted.
REQ-026 rdata_flat SHALL remain stable from MReady until a later load updates it, since the control unit writes registers while waiting.
REQ-027 MReady SHALL be 0 in IDLE and ACCESS; busy SHALL be 1 in ACCESS and DONE and 0 in IDLE.
REQ-028 Addresses SHALL be used modulo 2^ADDR_W (full index width, no out-of-range case).

Reset
REQ-029 With reset high at a rising edge, SHALL enter IDLE, clear the lane index, and drive MReady=0, busy=0 and rdata_flat=0.
REQ-030 Reset SHALL override any in-progress request: lanes not yet serviced are not written, and no MReady pulse follows.
REQ-031 Reset SHALL NOT clear memory contents; stores completed before reset persist.
REQ-032 Reset SHALL take priority over a simultaneous MRead or MWrite.

Verification
REQ-033 Store mask 4'b1111, addrs 1,2,3,4, data 10,20,30,40, then load same addrs with full mask -> rdata lanes 10,20,30,40; each MReady is a single pulse 5 cycles after its strobe edge.
REQ-034 Store mask 4'b0101 to addrs 5,6,7,8 with data 1,2,3,4 after mem[6]=mem[8]=0; then full load -> lanes read 1,0,3,0.
REQ-035 Store with all lanes at addr 9 and data 11,22,33,44, full mask -> subsequent load of addr 9 returns 44 on every lane.
REQ-036 MRead and MWrite both high -> treated as store (memory written, rdata unchanged); second MRead pulse during ACCESS -> ignored, exactly one MReady.
REQ-037 Reset asserted in the second ACCESS cycle of a 4-lane store -> lane 0 written, lanes 1-3 not written, MReady never pulses, busy=0 the cycle after reset.
REQ-038 Load with mask 4'b0000 -> MReady after 5 cycles and rdata_flat unchanged from the previous load.
